key_pulse_gen: RTL and testbench

KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

---
 rtl/key_pulse_gen_pkg.sv | 32 +++
 rtl/key_channel.sv | 102 ++++++++++
 rtl/key_pulse_gen.sv | 51 +++++
 tb/tb_key_pulse_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the six-key pulse generator: channel FSM encoding,
// key indices, pair-partner map and the saturating counter helper.
package key_pulse_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESS_DEB   = 3'd1,
    ST_HELD        = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_RELEASE_DEB = 3'd4
  } key_state_e;

  localparam int unsigned NUM_KEYS = 6;
  localparam int unsigned CNT_W    = 16;

  localparam int unsigned KEY_HU = 0;
  localparam int unsigned KEY_HD = 1;
  localparam int unsigned KEY_MU = 2;
  localparam int unsigned KEY_MD = 3;
  localparam int unsigned KEY_SU = 4;
  localparam int unsigned KEY_SD = 5;

  localparam int unsigned KEY_PARTNER [NUM_KEYS] =
    '{KEY_HD, KEY_HU, KEY_MD, KEY_MU, KEY_SD, KEY_SU};

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t cnt_sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce and auto-repeat FSM.
// pulse_o/level_o are combinational next-cycle values; the top registers them.
module key_channel
  import key_pulse_gen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 200,
  parameter int unsigned REP_DELAY  = 5000,
  parameter int unsigned REP_PERIOD = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic pulse_o,
  output logic level_o
);

  // The cycle that leaves IDLE/HELD already counts as the first stable cycle,
  // hence DEB_CYCLES-2 on the counter that is cleared on entry.
  localparam cnt_t DEB_LAST    = cnt_t'(DEB_CYCLES - 2);
  localparam cnt_t DELAY_LAST  = cnt_t'(REP_DELAY - 1);
  localparam cnt_t PERIOD_LAST = cnt_t'(REP_PERIOD - 1);

  logic       sync1_q, sync2_q;
  key_state_e state_q, state_d;
  cnt_t       deb_q, deb_d;
  cnt_t       rep_q, rep_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      deb_q   <= '0;
      rep_q   <= '0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      state_q <= state_d;
      deb_q   <= deb_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    rep_d   = rep_q;
    pulse_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          state_d = ST_PRESS_DEB;
          deb_d   = '0;
        end
      end
      ST_PRESS_DEB: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
        end else if (deb_q >= DEB_LAST) begin
          state_d = ST_HELD;
          rep_d   = '0;
          pulse_o = 1'b1;
        end else begin
          deb_d = cnt_sat_inc(deb_q);
        end
      end
      ST_HELD, ST_REPEAT: begin
        if (sync2_q) begin
          state_d = ST_RELEASE_DEB;
          deb_d   = '0;
        end else if (rep_q >= ((state_q == ST_HELD) ? DELAY_LAST : PERIOD_LAST)) begin
          state_d = ST_REPEAT;
          rep_d   = '0;
          pulse_o = 1'b1;
        end else begin
          rep_d = cnt_sat_inc(rep_q);
        end
      end
      ST_RELEASE_DEB: begin
        if (!sync2_q) begin
          state_d = ST_HELD;
          rep_d   = '0;
        end else if (deb_q >= DEB_LAST) begin
          state_d = ST_IDLE;
          deb_d   = '0;
          rep_d   = '0;
        end else begin
          deb_d = cnt_sat_inc(deb_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        deb_d   = '0;
        rep_d   = '0;
      end
    endcase
  end

  assign level_o = (state_d == ST_HELD) || (state_d == ST_REPEAT) ||
                   (state_d == ST_RELEASE_DEB);

endmodule

// File: rtl/key_pulse_gen.sv
// Six debounced keys with auto-repeat strobes and up/down pair lockout.
// Press pulse DEB_CYCLES+2 cycles after a clean raw edge; outputs registered.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 200,
  parameter int unsigned REP_DELAY  = 5000,
  parameter int unsigned REP_PERIOD = 1000
) (
  input  logic                CP,
  input  logic                CR_n,
  input  logic [NUM_KEYS-1:0] KEY_IN,
  output logic [NUM_KEYS-1:0] KEY_PULSE,
  output logic [NUM_KEYS-1:0] KEY_LEVEL
);

  logic [NUM_KEYS-1:0] ch_pulse, ch_level;
  logic [NUM_KEYS-1:0] pulse_d;
  logic [NUM_KEYS-1:0] pulse_q, level_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD)
    ) u_ch (
      .clk_i   (CP),
      .rst_ni  (CR_n),
      .key_ni  (KEY_IN[k]),
      .pulse_o (ch_pulse[k]),
      .level_o (ch_level[k])
    );

    // A pulse implies its own level, so this also kills simultaneous pulses.
    assign pulse_d[k] = ch_pulse[k] & ~(ch_level[k] & ch_level[KEY_PARTNER[k]]);
  end

  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      pulse_q <= '0;
      level_q <= '0;
    end else begin
      pulse_q <= pulse_d;
      level_q <= ch_level;
    end
  end

  assign KEY_PULSE = pulse_q;
  assign KEY_LEVEL = level_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen with DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8.
// Cycle c of a scenario: inputs change #1 after edge c, outputs sampled at the following negedge.
module tb_key_pulse_gen;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic       CP = 1'b0;
  logic       CR_n;
  logic [5:0] KEY_IN;
  logic [5:0] KEY_PULSE, KEY_LEVEL;

  key_pulse_gen #(.DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
    .CP        (CP),
    .CR_n      (CR_n),
    .KEY_IN    (KEY_IN),
    .KEY_PULSE (KEY_PULSE),
    .KEY_LEVEL (KEY_LEVEL)
  );

  always #5 CP = ~CP;

  typedef struct { int cyc; int b; logic v; } drv_t;          // b<0 drives CR_n
  typedef struct { int cyc; int b; } pev_t;
  typedef struct { int cyc; logic [5:0] mask; logic [5:0] val; } lvl_t;
  typedef struct { int b; int len; int n_pulses; } vec_t;

  drv_t drv_q[$];
  pev_t exp_q[$];
  lvl_t lvl_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulse_cnt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int cyc, input int b, input logic v);
    drv_t d;
    d.cyc = cyc; d.b = b; d.v = v;
    drv_q.push_back(d);
  endtask

  task automatic exp_pulse(input int cyc, input int b);
    pev_t e;
    e.cyc = cyc; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic exp_level(input int cyc, input logic [5:0] mask, input logic [5:0] val);
    lvl_t l;
    l.cyc = cyc; l.mask = mask; l.val = val;
    lvl_q.push_back(l);
  endtask

  // Reference model of one clean press held from t0 to t1 on an otherwise idle key.
  task automatic clean_hold(input int b, input int t0, input int t1);
    logic [5:0] m;
    logic       acc;
    m   = 6'b1 << b;
    acc = (t1 - t0) >= DEB;
    drive(t0, b, 1'b0);
    drive(t1, b, 1'b1);
    exp_level(t0 + DEB + 1, m, 6'b0);
    exp_level(t0 + DEB + 2, m, acc ? m : 6'b0);
    if (acc) begin
      exp_pulse(t0 + DEB + 2, b);
      for (int r = t0 + DEB + 2 + RD; r <= t1 + 2; r += RP) exp_pulse(r, b);
      exp_level(t1 + DEB + 1, m, m);
    end
    exp_level(t1 + DEB + 2, m, 6'b0);
  endtask

  task automatic run(input string name, input int ncyc);
    logic [5:0] ep;
    for (int b = 0; b < 6; b++) pulse_cnt[b] = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge CP);
      #1;
      foreach (drv_q[i]) begin
        if (drv_q[i].cyc == c) begin
          if (drv_q[i].b < 0) begin
            CR_n = drv_q[i].v;
            if (!drv_q[i].v) begin
              #1;
              check($sformatf("%s async reset outputs @%0d", name, c),
                    {20'b0, KEY_PULSE, KEY_LEVEL}, 32'b0);
            end
          end else begin
            KEY_IN[drv_q[i].b] = drv_q[i].v;
          end
        end
      end
      @(negedge CP);
      ep = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == c) begin
          ep[exp_q[i].b] = 1'b1;
          exp_q.delete(i);
        end
      end
      for (int b = 0; b < 6; b++) begin
        if (KEY_PULSE[b]) pulse_cnt[b]++;
        if (ep[b] || KEY_PULSE[b])
          check($sformatf("%s pulse[%0d] @%0d", name, b, c), {31'b0, KEY_PULSE[b]}, {31'b0, ep[b]});
      end
      for (int i = lvl_q.size() - 1; i >= 0; i--) begin
        if (lvl_q[i].cyc == c) begin
          check($sformatf("%s level @%0d", name, c),
                {26'b0, KEY_LEVEL & lvl_q[i].mask}, {26'b0, lvl_q[i].val});
          lvl_q.delete(i);
        end
      end
    end
    foreach (exp_q[i]) begin
      n_tests++; n_fail++;
      $display("FAIL %s pulse[%0d] @%0d: got none expected 1", name, exp_q[i].b, exp_q[i].cyc);
    end
    drv_q.delete(); exp_q.delete(); lvl_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    vec_t tbl [8];
    tbl = '{'{0, 60, 6}, '{1, 3, 0}, '{2, 4, 1}, '{3, 30, 2},
            '{4, 1, 0},  '{5, 27, 2}, '{1, 23, 1}, '{2, 24, 2}};

    KEY_IN = 6'b111110;
    CR_n   = 1'b0;
    repeat (3) @(posedge CP);
    #1;
    check("reset pulse", {26'b0, KEY_PULSE}, 32'b0);
    check("reset level", {26'b0, KEY_LEVEL}, 32'b0);
    KEY_IN = '1;
    @(posedge CP);
    #1;
    CR_n = 1'b1;
    @(negedge CP);
    @(negedge CP);
    check("first cycle after reset", {20'b0, KEY_PULSE, KEY_LEVEL}, 32'b0);
    repeat (4) @(posedge CP);

    foreach (tbl[i]) begin
      clean_hold(tbl[i].b, 0, tbl[i].len);
      run($sformatf("vec%0d", i), tbl[i].len + 12);
      check($sformatf("vec%0d pulse count", i), pulse_cnt[tbl[i].b], tbl[i].n_pulses);
    end

    // 1-cycle bounces on MU, stable low from cycle 10.
    for (int c = 0; c < 10; c++) drive(c, 2, logic'(c % 2));
    drive(10, 2, 1'b0);
    drive(30, 2, 1'b1);
    exp_pulse(16, 2);
    exp_level(12, 6'b000100, 6'b0);
    exp_level(15, 6'b000100, 6'b0);
    exp_level(16, 6'b000100, 6'b000100);
    exp_level(35, 6'b000100, 6'b000100);
    exp_level(36, 6'b000100, 6'b0);
    run("bounce", 45);

    // 2-cycle release glitch on HU; repeat timer restarts when HELD is re-entered.
    drive(0, 0, 1'b0);
    drive(15, 0, 1'b1);
    drive(17, 0, 1'b0);
    drive(70, 0, 1'b1);
    exp_pulse(6, 0);
    for (int r = 40; r <= 72; r += RP) exp_pulse(r, 0);
    exp_level(18, 6'b000001, 6'b000001);
    exp_level(20, 6'b000001, 6'b000001);
    exp_level(26, 6'b000001, 6'b000001);
    exp_level(75, 6'b000001, 6'b000001);
    exp_level(76, 6'b000001, 6'b0);
    run("release_glitch", 85);

    // Pair lockout: HU held, HD joins then leaves, MU independent, SU+SD together.
    drive(0, 0, 1'b0);
    drive(0, 4, 1'b0);
    drive(0, 5, 1'b0);
    drive(30, 1, 1'b0);
    drive(30, 2, 1'b0);
    drive(40, 4, 1'b1);
    drive(40, 5, 1'b1);
    drive(50, 1, 1'b1);
    drive(90, 0, 1'b1);
    drive(90, 2, 1'b1);
    exp_pulse(6, 0); exp_pulse(26, 0); exp_pulse(34, 0);
    for (int r = 58; r <= 92; r += RP) exp_pulse(r, 0);
    exp_pulse(36, 2);
    for (int r = 56; r <= 92; r += RP) exp_pulse(r, 2);
    exp_level(10, 6'b111111, 6'b110001);
    exp_level(36, 6'b111111, 6'b110111);
    exp_level(55, 6'b000010, 6'b000010);
    exp_level(56, 6'b111111, 6'b000101);
    exp_level(96, 6'b111111, 6'b000000);
    run("lockout", 100);

    // One-cycle reset in the middle of a hold; key re-debounced from scratch.
    drive(0, 0, 1'b0);
    drive(10, -1, 1'b0);
    drive(11, -1, 1'b1);
    drive(50, 0, 1'b1);
    exp_pulse(6, 0);
    exp_pulse(17, 0);
    exp_pulse(37, 0);
    exp_pulse(45, 0);
    exp_level(9, 6'b000001, 6'b000001);
    exp_level(10, 6'b000001, 6'b0);
    exp_level(16, 6'b000001, 6'b0);
    exp_level(17, 6'b000001, 6'b000001);
    exp_level(55, 6'b000001, 6'b000001);
    exp_level(56, 6'b000001, 6'b0);
    run("reset_mid_hold", 65);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
